// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers host writes and launches one byte per i_Tx_Done handshake.
// Optional sticky overflow flag on o_Overflow when UART_TX_FIFO_OVERFLOW_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Wr_DV,
    input  logic [7:0]            i_Wr_Byte,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Done,
    output logic                  o_Busy
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    output logic                  o_Overflow
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q;
    state_t                state_q;
    logic                  tx_dv_q, busy_q;
    logic [7:0]            tx_byte_q;
    logic                  wr_en, pop;

    // Fullness and pop eligibility come from registered state only.
    assign wr_en = i_Wr_DV && !full_q;
    assign pop   = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)
            count_d = count_q + 1'b1;
        else if (!wr_en && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset && wr_en)
            mem_q[wptr_q] <= i_Wr_Byte;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_en)
                wptr_q <= wptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            rptr_q    <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_byte_q <= mem_q[rptr_q];
                        rptr_q    <= rptr_q + 1'b1;
                        tx_dv_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= LAUNCH;
                    end
                end
                LAUNCH:    state_q <= WAIT_DONE;
                WAIT_DONE: if (i_Tx_Done) state_q <= GAP;
                GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow_q;
    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            overflow_q <= 1'b0;
        else if (i_Wr_DV && full_q)
            overflow_q <= 1'b1;
    end
    assign o_Overflow = overflow_q;
`endif

    assign o_Full    = full_q;
    assign o_Empty   = empty_q;
    assign o_Count   = count_q;
    assign o_Tx_DV   = tx_dv_q;
    assign o_Tx_Byte = tx_byte_q;
    assign o_Busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based model with a scheduled-launch view of the handshake.
module tb_uart_tx_fifo;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int VW    = DL + 13;

    logic          clk = 1'b0, rst = 1'b0, wr = 1'b0, done = 1'b0;
    logic [7:0]    wb = 8'h00;
    logic          full, empty, dv, busy;
    logic [DL:0]   cnt;
    logic [7:0]    txb;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic          ovf;
`endif

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(wr), .i_Wr_Byte(wb),
        .o_Full(full), .o_Empty(empty), .o_Count(cnt),
        .o_Tx_DV(dv), .o_Tx_Byte(txb), .i_Tx_Done(done), .o_Busy(busy)
`ifdef UART_TX_FIFO_OVERFLOW_EN
        , .o_Overflow(ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    // Model: queue holds bytes not yet handed to uart_tx; launch is allowed
    // once the previous byte's done has been seen and two cycles have elapsed.
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    int   cyc = 0, m_pop_cyc = 0, m_ready = 0;
    bit   m_wait = 0, m_dv = 0, m_busy = 0;
    logic [7:0] m_byte = 8'h00;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {cnt, full, empty, dv, txb, busy};

    function automatic logic [VW-1:0] exp_vec();
        logic [DL:0] c;
        c = (DL+1)'(mq.size());
        return {c, mq.size() == DEPTH, mq.size() == 0, m_dv, m_byte, m_busy};
    endfunction

    task automatic step(input bit r, input bit w, input logic [7:0] b, input bit d);
        bit pop, wok;
        rst = r; wr = w; wb = b; done = d;
        @(posedge clk); #1;
        cyc++;
        if (r) begin
            mq.delete(); m_wait = 0; m_ready = 0; m_dv = 0; m_byte = 8'h00; m_busy = 0;
        end else begin
            wok  = w && (mq.size() != DEPTH);
            pop  = !m_wait && (cyc >= m_ready) && (mq.size() != 0);
            m_dv = pop;
            if (m_wait && d && cyc >= m_pop_cyc + 2) begin
                m_wait = 0; m_ready = cyc + 2;
            end
            if (pop) begin
                m_byte = mq.pop_front(); m_wait = 1; m_pop_cyc = cyc;
            end
            if (wok) mq.push_back(b);
            m_busy = m_wait || (cyc < m_ready - 1);
        end
        if (dv) sent.push_back(txb);
        rst = 0; wr = 0; done = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_wait || m_busy || mq.size() != 0) && n < 5000) begin
            step(0, 0, 8'h00, m_wait && ($urandom_range(0, 3) == 0));
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else passed++;
            n++;
        end
        checks++;
        if (n >= 5000) $display("FAIL drain_timeout got=%0d exp=<5000", n);
        else passed++;
    endtask

    task automatic test_reset();
        int dv_seen = 0;
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, 0);
            if (dv) dv_seen++;
        end
        checks++; if (dv_seen !== 0) $display("FAIL reset_dv got=%0d exp=0", dv_seen); else passed++;
        checks++; if (cnt !== 0)     $display("FAIL reset_count got=%0d exp=0", cnt); else passed++;
        checks++; if (empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_flags got=e%b f%b b%b exp=e1 f0 b0", empty, full, busy); else passed++;
        checks++; if (txb !== 8'h00) $display("FAIL reset_byte got=%h exp=00", txb); else passed++;
    endtask

    task automatic test_single();
        step(0, 1, 8'hA5, 0);
        checks++; if (dv !== 1'b0 || cnt !== 1) $display("FAIL single_n got=dv%b c%0d exp=dv0 c1", dv, cnt); else passed++;
        step(0, 0, 8'h00, 0);
        checks++; if (dv !== 1'b1 || txb !== 8'hA5 || cnt !== 0 || busy !== 1'b1)
            $display("FAIL single_launch got=dv%b %h c%0d b%b exp=dv1 a5 c0 b1", dv, txb, cnt, busy); else passed++;
        step(0, 0, 8'h00, 0);
        checks++; if (dv !== 1'b0 || txb !== 8'hA5) $display("FAIL single_pulse got=dv%b %h exp=dv0 a5", dv, txb); else passed++;
        drain();
    endtask

    task automatic test_burst();
        step(0, 1, 8'hEE, 0);
        step(0, 0, 8'h00, 0);
        sent.delete();
        for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0);
        checks++; if (full !== 1'b1 || cnt !== 16) $display("FAIL burst_full got=f%b c%0d exp=f1 c16", full, cnt); else passed++;
        step(0, 1, 8'hFF, 0);
        checks++; if (full !== 1'b1 || cnt !== 16) $display("FAIL burst_drop got=f%b c%0d exp=f1 c16", full, cnt); else passed++;
`ifdef UART_TX_FIFO_OVERFLOW_EN
        checks++; if (ovf !== 1'b1) $display("FAIL burst_ovf got=%b exp=1", ovf); else passed++;
`endif
        drain();
        checks++; if (sent.size() !== 16) $display("FAIL burst_len got=%0d exp=16", sent.size()); else passed++;
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            checks++; if (sent[i] !== 8'(i)) $display("FAIL burst_order[%0d] got=%h exp=%h", i, sent[i], 8'(i)); else passed++;
        end
    endtask

    task automatic test_hold_done();
        int bad = 0;
        step(0, 1, 8'h3C, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h5A, 0);
        for (int i = 0; i < 1000; i++) begin
            step(0, 0, 8'h00, 0);
            if (dv !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL hold_wait got=%0d bad cycles exp=0", bad); else passed++;
        step(0, 0, 8'h00, 1);
        checks++; if (dv !== 1'b0 || busy !== 1'b1) $display("FAIL hold_gap got=dv%b b%b exp=dv0 b1", dv, busy); else passed++;
        step(0, 0, 8'h00, 0);
        checks++; if (dv !== 1'b0 || busy !== 1'b0) $display("FAIL hold_idle got=dv%b b%b exp=dv0 b0", dv, busy); else passed++;
        step(0, 0, 8'h00, 0);
        checks++; if (dv !== 1'b1 || txb !== 8'h5A) $display("FAIL hold_next got=dv%b %h exp=dv1 5a", dv, txb); else passed++;
        drain();
    endtask

    task automatic test_same_edge();
        sent.delete();
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        checks++; if (cnt !== 1 || dv !== 1'b1 || txb !== 8'h11)
            $display("FAIL same_edge got=c%0d dv%b %h exp=c1 dv1 11", cnt, dv, txb); else passed++;
        drain();
        checks++; if (sent.size() !== 2 || sent[0] !== 8'h11 || sent[1] !== 8'h22)
            $display("FAIL same_edge_order got=n%0d exp=n2 11,22", sent.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        int dv_seen = 0;
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h40 + i), 0);
        step(0, 0, 8'h00, 0);
        checks++; if (cnt !== 5 || busy !== 1'b1) $display("FAIL mid_pre got=c%0d b%b exp=c5 b1", cnt, busy); else passed++;
        step(1, 0, 8'h00, 0);
        checks++; if (cnt !== 0 || busy !== 1'b0 || empty !== 1'b1)
            $display("FAIL mid_reset got=c%0d b%b e%b exp=c0 b0 e1", cnt, busy, empty); else passed++;
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, 0);
            if (dv) dv_seen++;
        end
        checks++; if (dv_seen !== 0 || busy !== 1'b0) $display("FAIL mid_stale got=dv%0d b%b exp=dv0 b0", dv_seen, busy); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                 m_wait && ($urandom_range(0, 5) == 0));
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else passed++;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_hold_done();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit buffer placed directly upstream of `uart_tx`. It accepts bursts of bytes from the host logic, stores them in a circular FIFO, and feeds them to `uart_tx` one at a time. Each byte is sent by pulsing `o_Tx_DV` together with `o_Tx_Byte`, then waiting for `i_Tx_Done` before sending the next. Producers can therefore write back-to-back without tracking serial-line timing.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16 by default); legal range 1–8.
- `i_Clock` input 1: sole clock; all logic on its rising edge.
- `i_Reset` input 1: synchronous, active-high reset.
- `i_Wr_DV` input 1: write strobe; `i_Wr_Byte` is captured on any edge where `i_Wr_DV`=1 and `o_Full`=0.
- `i_Wr_Byte` input 8: byte to enqueue.
- `o_Full` output 1: registered; high when the count equals 2^DEPTH_LOG2.
- `o_Empty` output 1: registered; high when the count is 0.
- `o_Count` output DEPTH_LOG2+1: registered occupancy, 0 to 2^DEPTH_LOG2.
- `o_Tx_DV` output 1: one-cycle launch pulse to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte` output 8: byte to `uart_tx` `i_Tx_Byte`; held stable from launch until the next launch.
- `i_Tx_Done` input 1: `uart_tx` `o_Tx_Done`; indicates the current byte has finished (stop bit complete).
- `o_Busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Storage: 2^DEPTH_LOG2 × 8 register array.
- Pointers: DEPTH_LOG2-bit write and read pointers; each wraps naturally modulo depth.
- Count: separate counter of width DEPTH_LOG2+1.
- Write: accepted only if `o_Full`=0 at the edge. When accepted, `mem[wptr]` ← `i_Wr_Byte`, `wptr`++, count++.
- Write while full: dropped silently. Memory, pointers and count are unchanged.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE: if count≠0, load `o_Tx_Byte` ← `mem[rptr]`, `rptr`++, count--, then go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: `o_Tx_DV`=1 for exactly this state (one cycle), then go to WAIT_DONE.
- WAIT_DONE: stay until `i_Tx_Done`=1, then go to GAP. `i_Tx_Done` seen in IDLE, LAUNCH or GAP is ignored.
- GAP: one idle cycle so `uart_tx` returns to its idle state, then go to IDLE.
- Simultaneous write and pop on the same edge: both take effect, and the count is unchanged.
- Write to a full FIFO on the edge a pop occurs: the write is still dropped, because fullness is judged on the pre-edge `o_Full`.
- Write into an empty FIFO: the pop uses the registered count, so it starts on the following edge.
- Reset mid-transfer: the FSM goes to IDLE and the FIFO empties. The byte already launched continues on the line inside `uart_tx`; its later `i_Tx_Done` is ignored because the FSM is not in WAIT_DONE.

## Timing
- Reset values: `o_Full`=0, `o_Empty`=1, `o_Count`=0, `o_Tx_DV`=0, `o_Tx_Byte`=8'h00, `o_Busy`=0. Pointers are 0 and the FSM is in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Write-to-launch latency, empty FIFO, FSM idle:
  - write strobe at edge N;
  - count=1 after N;
  - pop at edge N+1;
  - `o_Tx_DV`=1 during cycle N+1 to N+2.
- `o_Count`, `o_Empty` and `o_Full` update on the edge following the write or pop that changes them.
- Inter-byte spacing (done to next launch): `i_Tx_Done` sampled at edge D, GAP during D to D+1, IDLE pop at D+2, `o_Tx_DV` high during D+2 to D+3.
- Throughput: one byte per UART frame plus 3 clocks.

## Configuration
- Macro `UART_TX_FIFO_OVERFLOW_EN`.
- Defined: adds output port `o_Overflow` (1 bit, reset 0).
  - Set on any edge where `i_Wr_DV`=1 and `o_Full`=1.
  - Sticky until `i_Reset`.
- Undefined: port and logic are absent; dropped writes leave no record.

## Test plan
- Reset, then idle 10 clocks -> `o_Empty`=1, `o_Count`=0, `o_Tx_DV` never asserted, `o_Tx_Byte`=8'h00.
- Single write 8'hA5 -> `o_Tx_DV` pulses exactly 1 cycle, 2 clocks after the strobe, with `o_Tx_Byte`=8'hA5. With `uart_tx` (CLKS_PER_BIT=87) attached, the serial line carries 0xA5.
- Burst of 16 writes 8'h00..8'h0F on consecutive clocks (depth 16) -> `o_Full`=1 after the 16th. A 17th write (8'hFF) is dropped. Launches occur in order 00..0F, each only after `i_Tx_Done`; 8'hFF is never sent. With the macro defined, `o_Overflow`=1.
- Hold `i_Tx_Done` low for 1000 clocks after a launch -> FSM stays in WAIT_DONE, no second `o_Tx_DV`, `o_Busy`=1. Pulse done -> next launch 3 clocks later.
- Write exactly on the pop edge at count=1 -> count stays 1, and both bytes are eventually sent in order.
- Assert `i_Reset` during WAIT_DONE with 5 bytes queued -> next edge `o_Count`=0 and `o_Busy`=0. A stale `i_Tx_Done` pulse afterwards causes no launch.
